bench_bist_ctrl: RTL and testbench

Built-in self-test driver and response compactor for the sequential benchmark cores in the clock-mesh synthesis flow. It sits on the opposite side of a benchmark's primary I/O: it generates pseudorandom patterns for the 3 primary inputs and compacts the 6 primary outputs into a 16-bit MISR signature. The block shares the DUT's clock mesh and reset, so a post-CTS run can be checked with one signature compare.

---
 rtl/bench_bist_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bench_bist_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bench_bist_ctrl.sv
// bench_bist_ctrl: LFSR pattern source and 16-bit MISR response compactor for a benchmark core.
// Define BIST_GOLDEN_CMP_EN to build the golden-signature comparator; otherwise pass is tied low.
module bench_bist_ctrl #(
  parameter int unsigned PAT_COUNT   = 1024,
  parameter int unsigned LAT         = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [15:0] MISR_GOLDEN = 16'h0000
) (
  input  logic        blif_clk_net,
  input  logic        blif_reset_net,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  dut_out,
  output logic [2:0]  dut_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] pat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] POLY       = 16'hB400;
  localparam logic [15:0] PAT_LAST   = 16'(PAT_COUNT - 32'd1);
  localparam logic [15:0] PAT_MAX    = 16'(PAT_COUNT);
  localparam logic [2:0]  DRAIN_LAST = 3'(LAT - 32'd1);

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = (cur >> 1) ^ (cur[0] ? POLY : 16'h0000);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic [5:0] din);
    misr_step = lfsr_step(cur) ^ {10'b00_0000_0000, din};
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] lfsr_r;
  logic [15:0] misr_r;
  logic [15:0] pat_cnt_r;
  logic [2:0]  drain_cnt_r;
  logic        busy_r;
  logic        done_r;
  logic        load_s;
  logic        abort_s;
  logic        run_s;
  logic        cap_en_s;

  assign run_s = (state_r == S_RUN);

  // Next-state decode; abort has priority in RUN/DRAIN, start is only heard in IDLE/DONE.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt_s = S_RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
          abort_s     = 1'b1;
        end else if (pat_cnt_r == PAT_LAST) begin
          state_nxt_s = (LAT > 32'd0) ? S_DRAIN : S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
          abort_s     = 1'b1;
        end else if (drain_cnt_r == DRAIN_LAST) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // The capture strobe is the RUN flag delayed by the DUT response latency.
  generate
    if (LAT == 0) begin : g_no_pipe
      assign cap_en_s = run_s;
    end else begin : g_pipe
      logic [LAT-1:0] vld_pipe_r;
      // Valid-flag shift register, flushed whenever a run starts or is aborted.
      always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
          vld_pipe_r <= '0;
        end else if (load_s || abort_s) begin
          vld_pipe_r <= '0;
        end else begin
          vld_pipe_r <= (vld_pipe_r << 1) | LAT'(run_s);
        end
      end
      assign cap_en_s = vld_pipe_r[LAT-1];
    end
  endgenerate

  // State, pattern source, compactor and counters.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_r     <= S_IDLE;
      lfsr_r      <= LFSR_SEED;
      misr_r      <= 16'h0000;
      pat_cnt_r   <= 16'h0000;
      drain_cnt_r <= 3'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_r == S_RUN) || (state_r == S_DRAIN);
      done_r  <= (state_r == S_DONE);
      if ((state_r == S_DRAIN) && !abort_s) begin
        drain_cnt_r <= drain_cnt_r + 3'd1;
      end else begin
        drain_cnt_r <= 3'd0;
      end
      if (load_s) begin
        lfsr_r    <= LFSR_SEED;
        misr_r    <= 16'h0000;
        pat_cnt_r <= 16'h0000;
      end else if (!abort_s) begin
        if (run_s) begin
          lfsr_r <= lfsr_step(lfsr_r);
        end
        if (run_s && (pat_cnt_r != PAT_MAX)) begin
          pat_cnt_r <= pat_cnt_r + 16'd1;
        end
        if (cap_en_s) begin
          misr_r <= misr_step(misr_r, dut_out);
        end
      end
    end
  end

  assign dut_in    = run_s ? lfsr_r[2:0] : 3'b000;
  assign busy      = busy_r;
  assign done      = done_r;
  assign signature = misr_r;
  assign pat_cnt   = pat_cnt_r;

`ifdef BIST_GOLDEN_CMP_EN
  assign pass = done_r & (misr_r == MISR_GOLDEN);
`else
  assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_bench_bist_ctrl.sv
// Directed bench for bench_bist_ctrl: four instances with different PAT_COUNT/LAT/golden settings.
module tb_bench_bist_ctrl;

`ifdef BIST_GOLDEN_CMP_EN
  localparam logic CMP_EN = 1'b1;
`else
  localparam logic CMP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [5:0] dut_out = 6'h00;

  logic [2:0] din0, din1, din2, din3;
  logic busy0, busy1, busy2, busy3;
  logic done0, done1, done2, done3;
  logic pass0, pass1, pass2, pass3;
  logic [15:0] sig0, sig1, sig2, sig3;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bench_bist_ctrl u0 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_in(din0), .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .pat_cnt(cnt0));

  bench_bist_ctrl #(.PAT_COUNT(2), .LAT(0)) u1 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_in(din1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .pat_cnt(cnt1));

  bench_bist_ctrl #(.PAT_COUNT(4), .LAT(3)) u2 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_in(din2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pat_cnt(cnt2));

  bench_bist_ctrl #(.PAT_COUNT(8), .LAT(1), .MISR_GOLDEN(16'h1234)) u3 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_in(din3), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3), .pat_cnt(cnt3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++; if (din0 !== 3'b000) begin n_err++; $display("FAIL rst_dut_in: got %b expected 000", din0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done0); end
    n_cmp++; if (pass0 !== 1'b0) begin n_err++; $display("FAIL rst_pass: got %b expected 0", pass0); end
    n_cmp++; if (sig0 !== 16'h0000) begin n_err++; $display("FAIL rst_sig: got %h expected 0000", sig0); end
    n_cmp++; if (cnt0 !== 16'h0000) begin n_err++; $display("FAIL rst_pat_cnt: got %h expected 0000", cnt0); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_default_run();
    logic [2:0] exp_seq [4];
    int edge_n;
    exp_seq = '{3'b001, 3'b000, 3'b000, 3'b100};
    dut_out = 6'h00;
    do_reset();
    pulse_start();
    edge_n = 0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (din0 !== exp_seq[k]) begin
        n_err++; $display("FAIL def_dut_in[%0d]: got %b expected %b", k, din0, exp_seq[k]);
      end
      if (k == 1) begin
        n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL def_busy: got %b expected 1", busy0); end
      end
      if (k < 3) begin
        tick();
        edge_n++;
      end
    end
    while ((done0 !== 1'b1) && (edge_n < 1100)) begin
      tick();
      edge_n++;
    end
    n_cmp++; if (edge_n !== 1026) begin n_err++; $display("FAIL def_done_edge: got %0d expected 1026", edge_n); end
    n_cmp++; if (sig0 !== 16'h0000) begin n_err++; $display("FAIL def_sig: got %h expected 0000", sig0); end
    n_cmp++; if (cnt0 !== 16'd1024) begin n_err++; $display("FAIL def_pat_cnt: got %0d expected 1024", cnt0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL def_busy_end: got %b expected 0", busy0); end
    n_cmp++; if (pass0 !== CMP_EN) begin n_err++; $display("FAIL def_pass: got %b expected %b", pass0, CMP_EN); end
  endtask

  task automatic test_lat0_short();
    dut_out = 6'h3F;
    do_reset();
    pulse_start();
    n_cmp++; if (din1 !== 3'b001) begin n_err++; $display("FAIL l0_dut_in: got %b expected 001", din1); end
    tick();
    n_cmp++; if (sig1 !== 16'h003F) begin n_err++; $display("FAIL l0_sig1: got %h expected 003f", sig1); end
    tick();
    n_cmp++; if (sig1 !== 16'hB420) begin n_err++; $display("FAIL l0_sig2: got %h expected b420", sig1); end
    n_cmp++; if (done1 !== 1'b0) begin n_err++; $display("FAIL l0_done_early: got %b expected 0", done1); end
    tick();
    n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL l0_done: got %b expected 1", done1); end
    n_cmp++; if (cnt1 !== 16'd2) begin n_err++; $display("FAIL l0_pat_cnt: got %0d expected 2", cnt1); end
    n_cmp++; if (sig1 !== 16'hB420) begin n_err++; $display("FAIL l0_sig_hold: got %h expected b420", sig1); end
    n_cmp++; if (pass1 !== 1'b0) begin n_err++; $display("FAIL l0_pass: got %b expected 0", pass1); end
  endtask

  task automatic test_drain();
    int busy_n;
    int upd_n;
    logic [15:0] prev;
    dut_out = 6'h01;
    do_reset();
    pulse_start();
    busy_n = 0;
    upd_n = 0;
    prev = sig2;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (busy2 === 1'b1) busy_n++;
      if (sig2 !== prev) upd_n++;
      prev = sig2;
      if ((i >= 4) && (i <= 6)) begin
        n_cmp++; if (din2 !== 3'b000) begin n_err++; $display("FAIL dr_dut_in[%0d]: got %b expected 000", i, din2); end
      end
      if (i == 7) begin
        n_cmp++; if (done2 !== 1'b0) begin n_err++; $display("FAIL dr_done_early: got %b expected 0", done2); end
      end
      if (i == 8) begin
        n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL dr_done: got %b expected 1", done2); end
      end
    end
    n_cmp++; if (busy_n !== 7) begin n_err++; $display("FAIL dr_busy_cycles: got %0d expected 7", busy_n); end
    n_cmp++; if (upd_n !== 4) begin n_err++; $display("FAIL dr_misr_updates: got %0d expected 4", upd_n); end
    n_cmp++; if (sig2 !== 16'hC301) begin n_err++; $display("FAIL dr_sig: got %h expected c301", sig2); end
    n_cmp++; if (cnt2 !== 16'd4) begin n_err++; $display("FAIL dr_pat_cnt: got %0d expected 4", cnt2); end
  endtask

  task automatic test_abort();
    dut_out = 6'h15;
    do_reset();
    pulse_start();
    tick();
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    n_cmp++; if (din3 !== 3'b000) begin n_err++; $display("FAIL ab_dut_in: got %b expected 000", din3); end
    n_cmp++; if (cnt3 !== 16'd2) begin n_err++; $display("FAIL ab_pat_cnt: got %0d expected 2", cnt3); end
    n_cmp++; if (sig3 !== 16'h0015) begin n_err++; $display("FAIL ab_sig: got %h expected 0015", sig3); end
    tick();
    tick();
    tick();
    n_cmp++; if (done3 !== 1'b0) begin n_err++; $display("FAIL ab_done: got %b expected 0", done3); end
    n_cmp++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL ab_busy: got %b expected 0", busy3); end
    n_cmp++; if (sig3 !== 16'h0015) begin n_err++; $display("FAIL ab_sig_frozen: got %h expected 0015", sig3); end
    n_cmp++; if (cnt3 !== 16'd2) begin n_err++; $display("FAIL ab_cnt_frozen: got %0d expected 2", cnt3); end
    pulse_start();
    n_cmp++; if (din3 !== 3'b001) begin n_err++; $display("FAIL ab_restart_dut_in: got %b expected 001", din3); end
    n_cmp++; if (sig3 !== 16'h0000) begin n_err++; $display("FAIL ab_restart_sig: got %h expected 0000", sig3); end
    n_cmp++; if (cnt3 !== 16'd0) begin n_err++; $display("FAIL ab_restart_cnt: got %0d expected 0", cnt3); end
  endtask

  task automatic test_reset_mid_drain();
    int edge_n;
    dut_out = 6'h01;
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (sig2 !== 16'hB401) begin n_err++; $display("FAIL rm_sig_pre: got %h expected b401", sig2); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b expected 0", busy2); end
    n_cmp++; if (done2 !== 1'b0) begin n_err++; $display("FAIL rm_done: got %b expected 0", done2); end
    n_cmp++; if (pass2 !== 1'b0) begin n_err++; $display("FAIL rm_pass: got %b expected 0", pass2); end
    n_cmp++; if (sig2 !== 16'h0000) begin n_err++; $display("FAIL rm_sig: got %h expected 0000", sig2); end
    n_cmp++; if (cnt2 !== 16'h0000) begin n_err++; $display("FAIL rm_pat_cnt: got %h expected 0000", cnt2); end
    n_cmp++; if (din2 !== 3'b000) begin n_err++; $display("FAIL rm_dut_in: got %b expected 000", din2); end
    #1;
    rst = 1'b0;
    tick();
    pulse_start();
    edge_n = 0;
    while ((done2 !== 1'b1) && (edge_n < 30)) begin
      tick();
      edge_n++;
    end
    n_cmp++; if (edge_n !== 8) begin n_err++; $display("FAIL rm_done_edge: got %0d expected 8", edge_n); end
    n_cmp++; if (sig2 !== 16'hC301) begin n_err++; $display("FAIL rm_sig_rerun: got %h expected c301", sig2); end
    n_cmp++; if (cnt2 !== 16'd4) begin n_err++; $display("FAIL rm_cnt_rerun: got %0d expected 4", cnt2); end
  endtask

  task automatic test_golden();
    int edge_n;
    dut_out = 6'h00;
    do_reset();
    pulse_start();
    edge_n = 0;
    while ((done3 !== 1'b1) && (edge_n < 30)) begin
      tick();
      edge_n++;
    end
    n_cmp++; if (edge_n !== 10) begin n_err++; $display("FAIL gd_done_edge: got %0d expected 10", edge_n); end
    n_cmp++; if (sig3 !== 16'h0000) begin n_err++; $display("FAIL gd_sig: got %h expected 0000", sig3); end
    n_cmp++; if (cnt3 !== 16'd8) begin n_err++; $display("FAIL gd_pat_cnt: got %0d expected 8", cnt3); end
    n_cmp++; if (pass3 !== 1'b0) begin n_err++; $display("FAIL gd_pass: got %b expected 0", pass3); end
  endtask

  initial begin
    #2;
    test_reset();
    test_default_run();
    test_lat0_short();
    test_drain();
    test_abort();
    test_reset_mid_drain();
    test_golden();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
